wide_uart_rx: RTL

WIDE_UART_RX -- requirements
Module: wide_uart_rx

---
 rtl/wide_uart_rx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wide_uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : wide_uart_rx                                                 |
// | Brief   : 8N1 UART receiver packing eight bytes into a 64-bit          |
// |           AXI-Stream beat. Define WIDE_UART_RX_TIMEOUT_EN to enable    |
// |           the inter-byte timeout that discards partial words.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module wide_uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RsRx,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TMR_W        = $clog2(CLKS_PER_BIT);

    localparam logic [TMR_W-1:0] c_TMR_HALF = TMR_W'(CLKS_PER_BIT / 2);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_BREAK = 3'd4;

    logic             r_sync1_q, r_sync2_q;
    logic [2:0]       r_state_q, w_state_d;
    logic [TMR_W-1:0] r_tmr_q, w_tmr_d;
    logic [2:0]       r_bit_q, w_bit_d;
    logic [7:0]       r_shift_q, w_shift_d;
    logic [2:0]       r_idx_q, w_idx_d;
    logic [55:0]      r_asm_q, w_asm_d;
    logic [63:0]      r_tdata_q, w_tdata_d;
    logic             r_tvalid_q, w_tvalid_d;
    logic             r_frame_err_q, w_frame_err_d;
    logic             r_overrun_q, w_overrun_d;
    logic             w_rx;
    logic             w_byte_done;

`ifdef WIDE_UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TO_LIMIT - 1);

    logic [TO_W-1:0] r_to_cnt_q, w_to_cnt_d;
    logic            r_timeout_q, w_timeout_d;
`endif

    assign w_rx = r_sync2_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_tmr_d       = r_tmr_q;
        w_bit_d       = r_bit_q;
        w_shift_d     = r_shift_q;
        w_idx_d       = r_idx_q;
        w_asm_d       = r_asm_q;
        w_tdata_d     = r_tdata_q;
        w_tvalid_d    = r_tvalid_q;
        w_frame_err_d = 1'b0;
        w_overrun_d   = 1'b0;
        w_byte_done   = 1'b0;
`ifdef WIDE_UART_RX_TIMEOUT_EN
        w_to_cnt_d    = '0;
        w_timeout_d   = 1'b0;
`endif

        case (r_state_q)
            c_IDLE: begin
                w_tmr_d = '0;
                if (!w_rx) w_state_d = c_START;
            end
            c_START: begin
                if (r_tmr_q == c_TMR_HALF) begin
                    w_tmr_d   = '0;
                    w_bit_d   = 3'd0;
                    w_state_d = w_rx ? c_IDLE : c_DATA;
                end else begin
                    w_tmr_d = r_tmr_q + TMR_W'(1);
                end
            end
            c_DATA: begin
                if (r_tmr_q == c_TMR_LAST) begin
                    w_tmr_d   = '0;
                    w_shift_d = {w_rx, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + 3'd1;
                    if (r_bit_q == 3'd7) w_state_d = c_STOP;
                end else begin
                    w_tmr_d = r_tmr_q + TMR_W'(1);
                end
            end
            c_STOP: begin
                if (r_tmr_q == c_TMR_LAST) begin
                    w_tmr_d = '0;
                    if (w_rx) begin
                        w_byte_done = 1'b1;
                        w_state_d   = c_IDLE;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_idx_d       = 3'd0;
                        w_state_d     = c_BREAK;
                    end
                end else begin
                    w_tmr_d = r_tmr_q + TMR_W'(1);
                end
            end
            c_BREAK: begin
                if (w_rx) w_state_d = c_IDLE;
            end
            default: w_state_d = c_IDLE;
        endcase

        if (r_tvalid_q && m_axis_tready) w_tvalid_d = 1'b0;

        // Bytes shift in from the bottom, so after eight the first lands in [63:56].
        if (w_byte_done) begin
            w_asm_d = {r_asm_q[47:0], r_shift_q};
            w_idx_d = r_idx_q + 3'd1;
            if (r_idx_q == 3'd7) begin
                if (!r_tvalid_q || m_axis_tready) begin
                    w_tdata_d  = {r_asm_q, r_shift_q};
                    w_tvalid_d = 1'b1;
                end else begin
                    w_overrun_d = 1'b1;
                end
            end
        end

`ifdef WIDE_UART_RX_TIMEOUT_EN
        if (r_state_q == c_IDLE && w_rx && r_idx_q != 3'd0) begin
            if (r_to_cnt_q == c_TO_LAST) begin
                w_idx_d     = 3'd0;
                w_timeout_d = 1'b1;
            end else begin
                w_to_cnt_d = r_to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q     <= 1'b1;
            r_sync2_q     <= 1'b1;
            r_state_q     <= c_IDLE;
            r_tmr_q       <= '0;
            r_bit_q       <= 3'd0;
            r_shift_q     <= 8'd0;
            r_idx_q       <= 3'd0;
            r_asm_q       <= 56'd0;
            r_tdata_q     <= 64'd0;
            r_tvalid_q    <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_overrun_q   <= 1'b0;
        end else begin
            r_sync1_q     <= RsRx;
            r_sync2_q     <= r_sync1_q;
            r_state_q     <= w_state_d;
            r_tmr_q       <= w_tmr_d;
            r_bit_q       <= w_bit_d;
            r_shift_q     <= w_shift_d;
            r_idx_q       <= w_idx_d;
            r_asm_q       <= w_asm_d;
            r_tdata_q     <= w_tdata_d;
            r_tvalid_q    <= w_tvalid_d;
            r_frame_err_q <= w_frame_err_d;
            r_overrun_q   <= w_overrun_d;
        end
    end

`ifdef WIDE_UART_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt_q  <= '0;
            r_timeout_q <= 1'b0;
        end else begin
            r_to_cnt_q  <= w_to_cnt_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign timeout = r_timeout_q;
`else
    logic w_unused_timeout_bits;
    assign w_unused_timeout_bits = (TIMEOUT_BITS == 0);
    assign timeout               = 1'b0;
`endif

    assign m_axis_tdata  = r_tdata_q;
    assign m_axis_tvalid = r_tvalid_q;
    assign frame_err     = r_frame_err_q;
    assign overrun       = r_overrun_q;

endmodule
`default_nettype wire
